wb_mem_arbiter: RTL and testbench
=================================

// Module: wb_mem_arbiter
// PURPOSE
//  Two-master, one-slave Wishbone B4 arbiter in front of the shared external RAM (wb_ram).
//  Master 0 is the ao486 CPU memory bus (wbm_cpu_mem_*); master 1 is a secondary agent such as a DMA or loader.
//  Round-robin grant, held for a whole cycle (cyc high, including cti bursts).
//  Per-transfer ack watchdog ends a hung slave access with err instead of stalling the CPU.
// PARAMETERS
//  AW       32  address width, all ports
//  DW       32  data width, all ports; sel width = DW/8
//  TIMEOUT  256 clocks a granted stb may wait for ack/err/rty before a forced err; 0 disables the watchdog
// PORTS
//  wb_clk_i     in  1      system clock, all logic on rising edge
//  wb_rst_i     in  1      asynchronous, active-high reset
//  mN_adr_i     in  AW     master N address (N = 0,1; same for all mN_ lines)
//  mN_dat_i     in  DW     master N write data
//  mN_sel_i     in  DW/8   master N byte select
//  mN_we_i, mN_cyc_i, mN_stb_i       in  1 each  master N control
//  mN_cti_i     in  3      master N cycle type
//  mN_bte_i     in  2      master N burst type
//  mN_dat_o     out DW     read data to master N
//  mN_ack_o, mN_err_o, mN_rty_o      out 1 each  termination to master N
//  s_adr_o, s_dat_o, s_sel_o, s_we_o, s_cyc_o, s_stb_o, s_cti_o, s_bte_o  out  slave request, widths as master
//  s_dat_i      in  DW     slave read data
//  s_ack_i, s_err_i, s_rty_i         in  1 each  slave termination
//  gnt_o        out 2      one-hot current owner; 2'b00 = idle
//  timeout_o    out 1      one-clock pulse when the watchdog fires
// BEHAVIOUR
//  - Reset, asynchronous: state IDLE, gnt_o = 0, last owner = 1 (so m0 wins the first tie), watchdog count = 0.
//    All outputs are 0 while reset is asserted, including s_cyc_o and s_stb_o. This applies mid-burst.
//  - States: IDLE, OWN0, OWN1. Owner-select is registered.
//  - Latency: one clock from mN_cyc_i rising to s_cyc_o rising.
//  - IDLE: only m0 requests -> OWN0; only m1 -> OWN1.
//    Both request -> the master that was not last owner; last owner updates on each grant.
//  - OWNn: stay while mn_cyc_i = 1.
//    On the edge where mn_cyc_i = 0: if the other master has cyc = 1, go directly to its OWN state
//    (no idle clock) and update last owner; otherwise go to IDLE.
//  - Request path is combinational from the owner. s_adr/dat/sel/we/cti/bte_o = owner inputs.
//    s_cyc_o = owner cyc; s_stb_o = owner stb. In IDLE, s_cyc_o = s_stb_o = 0 and the other s_ outputs are 0.
//  - Response path is combinational to the owner: mn_dat_o = s_dat_i, and ack/err/rty are routed to the owner.
//    The non-owner sees ack/err/rty = 0 and dat_o = 0. The non-owner's stb is never forwarded.
//  - Watchdog: counts clocks with owner stb = 1 and s_ack_i | s_err_i | s_rty_i = 0.
//    It clears on any termination, on stb = 0, and on an ownership change.
//    When count == TIMEOUT-1 with no termination that clock: owner err_o = 1 for that clock, timeout_o pulses,
//    and the counter clears. s_stb_o is forced to 0 for that clock so the master and slave see a consistent end.
//    A slave ack on the same clock has priority: no err, no pulse.
//  - Counter width is clog2(TIMEOUT+1); it saturates and never wraps. With TIMEOUT = 0 it is held at 0.
//  - Bursts: cti/bte pass through unchanged. The grant cannot change inside a burst because grant is cyc-based.
//  - A master that drops cyc with stb high and no ack is an illegal master; the arbiter still releases on cyc = 0.
// TESTING
//  - m0 single read at 0x1FFFFF0 with slave ack after 2 clocks.
//    -> s_cyc_o one clock after m0_cyc_i; m0_dat_o = 32'heb03eb03; gnt_o = 01; m1 sees no ack.
//  - m0 and m1 raise cyc on the same clock from reset.
//    -> m0 granted first; on m0 cyc drop, gnt_o goes 01 -> 10 on the next edge with no idle clock.
//  - Both masters hold continuous requests for 8 transactions.
//    -> grants alternate 01,10,01,10...; a 4-beat incrementing burst (cti = 010, last 111) is never split.
//  - TIMEOUT = 16, slave never acks m1.
//    -> m1_err_o high exactly 16 clocks after stb, timeout_o one pulse, s_stb_o low that clock; ack at clock 16 instead gives no err.
//  - Assert wb_rst_i mid-burst while OWN1.
//    -> s_cyc_o, s_stb_o, gnt_o drop immediately (no clock edge); after release m0 wins the first tie.

Source files
------------

// File: rtl/wb_mem_arbiter.sv
// Two-master, one-slave Wishbone B4 arbiter with round-robin grant held per cycle,
// plus a per-transfer ack watchdog that ends a hung slave access with err.
module wb_mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 256
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,

  input  logic [AW-1:0]   m0_adr_i,
  input  logic [DW-1:0]   m0_dat_i,
  input  logic [DW/8-1:0] m0_sel_i,
  input  logic            m0_we_i,
  input  logic            m0_cyc_i,
  input  logic            m0_stb_i,
  input  logic [2:0]      m0_cti_i,
  input  logic [1:0]      m0_bte_i,
  output logic [DW-1:0]   m0_dat_o,
  output logic            m0_ack_o,
  output logic            m0_err_o,
  output logic            m0_rty_o,

  input  logic [AW-1:0]   m1_adr_i,
  input  logic [DW-1:0]   m1_dat_i,
  input  logic [DW/8-1:0] m1_sel_i,
  input  logic            m1_we_i,
  input  logic            m1_cyc_i,
  input  logic            m1_stb_i,
  input  logic [2:0]      m1_cti_i,
  input  logic [1:0]      m1_bte_i,
  output logic [DW-1:0]   m1_dat_o,
  output logic            m1_ack_o,
  output logic            m1_err_o,
  output logic            m1_rty_o,

  output logic [AW-1:0]   s_adr_o,
  output logic [DW-1:0]   s_dat_o,
  output logic [DW/8-1:0] s_sel_o,
  output logic            s_we_o,
  output logic            s_cyc_o,
  output logic            s_stb_o,
  output logic [2:0]      s_cti_o,
  output logic [1:0]      s_bte_o,
  input  logic [DW-1:0]   s_dat_i,
  input  logic            s_ack_i,
  input  logic            s_err_i,
  input  logic            s_rty_i,

  output logic [1:0]      gnt_o,
  output logic            timeout_o
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_nxt;
  logic          last_owner, last_owner_nxt;
  logic [CW-1:0] wd_cnt, wd_cnt_nxt;
  logic          own_stb, term, fire;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      last_owner <= 1'b1;
      wd_cnt     <= '0;
    end else begin
      state      <= state_nxt;
      last_owner <= last_owner_nxt;
      wd_cnt     <= wd_cnt_nxt;
    end
  end

  // Ownership only moves when the current owner drops cyc, so bursts are never split.
  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    case (state)
      IDLE: begin
        if (m0_cyc_i && (!m1_cyc_i || last_owner)) begin
          state_nxt      = OWN0;
          last_owner_nxt = 1'b0;
        end else if (m1_cyc_i) begin
          state_nxt      = OWN1;
          last_owner_nxt = 1'b1;
        end
      end
      OWN0: begin
        if (!m0_cyc_i) begin
          if (m1_cyc_i) begin
            state_nxt      = OWN1;
            last_owner_nxt = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      OWN1: begin
        if (!m1_cyc_i) begin
          if (m0_cyc_i) begin
            state_nxt      = OWN0;
            last_owner_nxt = 1'b0;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Watchdog: a slave termination in the same clock always wins over a forced err.
  always_comb begin
    term    = s_ack_i | s_err_i | s_rty_i;
    own_stb = ((state == OWN0) && m0_stb_i) || ((state == OWN1) && m1_stb_i);
    fire    = (TIMEOUT != 0) && own_stb && !term && (wd_cnt == CW'(TIMEOUT - 1));
    if ((TIMEOUT == 0) || (state_nxt != state) || !own_stb || term || fire)
      wd_cnt_nxt = '0;
    else if (wd_cnt != CW'(TIMEOUT))
      wd_cnt_nxt = wd_cnt + CW'(1);
    else
      wd_cnt_nxt = wd_cnt;
  end

  always_comb begin
    s_adr_o  = '0;
    s_dat_o  = '0;
    s_sel_o  = '0;
    s_we_o   = 1'b0;
    s_cyc_o  = 1'b0;
    s_stb_o  = 1'b0;
    s_cti_o  = '0;
    s_bte_o  = '0;
    m0_dat_o = '0;
    m0_ack_o = 1'b0;
    m0_err_o = 1'b0;
    m0_rty_o = 1'b0;
    m1_dat_o = '0;
    m1_ack_o = 1'b0;
    m1_err_o = 1'b0;
    m1_rty_o = 1'b0;
    case (state)
      OWN0: begin
        s_adr_o  = m0_adr_i;
        s_dat_o  = m0_dat_i;
        s_sel_o  = m0_sel_i;
        s_we_o   = m0_we_i;
        s_cyc_o  = m0_cyc_i;
        s_stb_o  = m0_stb_i & ~fire;
        s_cti_o  = m0_cti_i;
        s_bte_o  = m0_bte_i;
        m0_dat_o = s_dat_i;
        m0_ack_o = s_ack_i;
        m0_err_o = s_err_i | fire;
        m0_rty_o = s_rty_i;
      end
      OWN1: begin
        s_adr_o  = m1_adr_i;
        s_dat_o  = m1_dat_i;
        s_sel_o  = m1_sel_i;
        s_we_o   = m1_we_i;
        s_cyc_o  = m1_cyc_i;
        s_stb_o  = m1_stb_i & ~fire;
        s_cti_o  = m1_cti_i;
        s_bte_o  = m1_bte_i;
        m1_dat_o = s_dat_i;
        m1_ack_o = s_ack_i;
        m1_err_o = s_err_i | fire;
        m1_rty_o = s_rty_i;
      end
      default: ;
    endcase
  end

  assign gnt_o     = {state == OWN1, state == OWN0};
  assign timeout_o = fire;

endmodule

// File: tb/tb_wb_mem_arbiter.sv
// Self-checking bench for wb_mem_arbiter: bench-side slave model, random master traffic,
// expected grant order and read data derived from the arbitration rules.
module tb_wb_mem_arbiter;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [31:0] m_adr [2];
  logic [31:0] m_dat [2];
  logic [3:0]  m_sel [2];
  logic        m_we  [2];
  logic        m_cyc [2];
  logic        m_stb [2];
  logic [2:0]  m_cti [2];
  logic [1:0]  m_bte [2];

  logic [31:0] m0_dat_o, m1_dat_o;
  logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o;
  logic [2:0]  s_cti_o;
  logic [1:0]  s_bte_o;
  logic [31:0] s_dat_i;
  logic        s_ack_i;
  logic        s_err_i = 1'b0;
  logic        s_rty_i = 1'b0;
  logic [1:0]  gnt_o;
  logic        timeout_o;

  int n_checks = 0;
  int n_pass   = 0;
  int slave_lat = 1;
  bit slave_mute = 1'b0;
  int s_wait;
  int grant_log [$];

  wb_mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .m0_adr_i(m_adr[0]), .m0_dat_i(m_dat[0]), .m0_sel_i(m_sel[0]), .m0_we_i(m_we[0]),
    .m0_cyc_i(m_cyc[0]), .m0_stb_i(m_stb[0]), .m0_cti_i(m_cti[0]), .m0_bte_i(m_bte[0]),
    .m0_dat_o(m0_dat_o), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
    .m1_adr_i(m_adr[1]), .m1_dat_i(m_dat[1]), .m1_sel_i(m_sel[1]), .m1_we_i(m_we[1]),
    .m1_cyc_i(m_cyc[1]), .m1_stb_i(m_stb[1]), .m1_cti_i(m_cti[1]), .m1_bte_i(m_bte[1]),
    .m1_dat_o(m1_dat_o), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_cti_o(s_cti_o), .s_bte_o(s_bte_o),
    .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
    .gnt_o(gnt_o), .timeout_o(timeout_o)
  );

  function automatic logic [31:0] slave_rd(input logic [31:0] a);
    if (a == 32'h01FF_FFF0) return 32'heb03eb03;
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  function automatic logic get_ack(input int m);
    return (m == 0) ? m0_ack_o : m1_ack_o;
  endfunction

  function automatic logic [31:0] get_dat(input int m);
    return (m == 0) ? m0_dat_o : m1_dat_o;
  endfunction

  // Slave model: acks slave_lat clocks after stb is first seen, one-clock ack pulses.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      s_ack_i <= 1'b0;
      s_dat_i <= '0;
      s_wait  <= 0;
    end else begin
      s_ack_i <= 1'b0;
      if (s_cyc_o && s_stb_o && !s_ack_i && !slave_mute) begin
        if (s_wait + 1 >= slave_lat) begin
          s_ack_i <= 1'b1;
          s_dat_i <= s_we_o ? 32'h0 : slave_rd(s_adr_o);
          s_wait  <= 0;
        end else begin
          s_wait <= s_wait + 1;
        end
      end else if (!(s_cyc_o && s_stb_o)) begin
        s_wait <= 0;
      end
    end
  end

  task automatic idle_master(input int m);
    m_adr[m] = '0; m_dat[m] = '0; m_sel[m] = '0; m_we[m] = 1'b0;
    m_cyc[m] = 1'b0; m_stb[m] = 1'b0; m_cti[m] = '0; m_bte[m] = '0;
  endtask

  task automatic raise_master(input int m, input logic [31:0] adr, input logic [2:0] cti);
    m_adr[m] = adr; m_sel[m] = 4'hF; m_we[m] = 1'b0; m_cti[m] = cti;
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1;
  endtask

  task automatic do_reset;
    idle_master(0);
    idle_master(1);
    slave_mute = 1'b0;
    slave_lat  = 1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // One master cycle of 'beats' transfers; checks grant, pass-through and data on every ack.
  task automatic run_txn(input int m, input logic [31:0] adr, input logic we, input int beats);
    int budget;
    m_cyc[m] = 1'b1; m_stb[m] = 1'b1; m_we[m] = we; m_sel[m] = 4'hF; m_bte[m] = 2'b00;
    for (int b = 0; b < beats; b++) begin
      m_adr[m] = adr + 32'(b * 4);
      m_dat[m] = $urandom;
      m_cti[m] = (beats == 1) ? 3'b000 : (b == beats - 1) ? 3'b111 : 3'b010;
      budget = 0;
      do begin
        @(negedge clk);
        budget++;
      end while (!get_ack(m) && budget < 200);
      n_checks++;
      if (!get_ack(m)) $display("[TB] FAIL txn_ack m%0d beat %0d: no ack after %0d clocks", m, b, budget);
      else n_pass++;
      if (b == 0) grant_log.push_back(m);
      n_checks++;
      if (gnt_o !== 2'(1 << m)) $display("[TB] FAIL burst_gnt m%0d beat %0d: got %b want %b", m, b, gnt_o, 2'(1 << m));
      else n_pass++;
      n_checks++;
      if (s_cti_o !== m_cti[m]) $display("[TB] FAIL cti_pass m%0d: got %b want %b", m, s_cti_o, m_cti[m]);
      else n_pass++;
      n_checks++;
      if (!we && get_dat(m) !== slave_rd(m_adr[m]))
        $display("[TB] FAIL read_data m%0d: got %h want %h", m, get_dat(m), slave_rd(m_adr[m]));
      else if (we && s_dat_o !== m_dat[m])
        $display("[TB] FAIL write_data m%0d: got %h want %h", m, s_dat_o, m_dat[m]);
      else n_pass++;
    end
    idle_master(m);
  endtask

  task automatic test_reset;
    idle_master(0);
    idle_master(1);
    rst = 1'b1;
    raise_master(0, 32'h0000_1000, 3'b000);
    raise_master(1, 32'h0000_2000, 3'b000);
    @(negedge clk);
    n_checks++; if (gnt_o !== 2'b00) $display("[TB] FAIL reset_gnt: got %b want 00", gnt_o); else n_pass++;
    n_checks++; if (s_cyc_o !== 1'b0) $display("[TB] FAIL reset_s_cyc: got %b want 0", s_cyc_o); else n_pass++;
    n_checks++; if (s_stb_o !== 1'b0) $display("[TB] FAIL reset_s_stb: got %b want 0", s_stb_o); else n_pass++;
    n_checks++; if (s_adr_o !== 32'h0) $display("[TB] FAIL reset_s_adr: got %h want 0", s_adr_o); else n_pass++;
    n_checks++; if (timeout_o !== 1'b0) $display("[TB] FAIL reset_timeout: got %b want 0", timeout_o); else n_pass++;
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (gnt_o !== 2'b01) $display("[TB] FAIL reset_first_tie: got %b want 01", gnt_o); else n_pass++;
    idle_master(0);
    idle_master(1);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single_read;
    int ack_k;
    do_reset;
    slave_lat = 2;
    raise_master(0, 32'h01FF_FFF0, 3'b000);
    #1;
    n_checks++; if (s_cyc_o !== 1'b0) $display("[TB] FAIL read_cyc_early: got %b want 0", s_cyc_o); else n_pass++;
    @(negedge clk);
    n_checks++; if (s_cyc_o !== 1'b1) $display("[TB] FAIL read_cyc_latency: got %b want 1", s_cyc_o); else n_pass++;
    n_checks++; if (gnt_o !== 2'b01) $display("[TB] FAIL read_gnt: got %b want 01", gnt_o); else n_pass++;
    n_checks++; if (s_adr_o !== 32'h01FF_FFF0) $display("[TB] FAIL read_adr: got %h want 01fffff0", s_adr_o); else n_pass++;
    ack_k = 1;
    while (!m0_ack_o && ack_k < 50) begin
      @(negedge clk);
      ack_k++;
    end
    n_checks++; if (ack_k !== 3) $display("[TB] FAIL read_ack_clock: got %0d want 3", ack_k); else n_pass++;
    n_checks++; if (m0_dat_o !== 32'heb03eb03) $display("[TB] FAIL read_dat: got %h want eb03eb03", m0_dat_o); else n_pass++;
    n_checks++; if (m1_ack_o !== 1'b0 || m1_dat_o !== 32'h0)
      $display("[TB] FAIL read_nonowner: got ack %b dat %h want 0 0", m1_ack_o, m1_dat_o); else n_pass++;
    idle_master(0);
    @(negedge clk);
    n_checks++; if (gnt_o !== 2'b00) $display("[TB] FAIL read_release: got %b want 00", gnt_o); else n_pass++;
  endtask

  task automatic test_back_to_back;
    do_reset;
    slave_lat = 1;
    raise_master(0, 32'h0000_0100, 3'b000);
    raise_master(1, 32'h0000_0200, 3'b000);
    @(negedge clk);
    n_checks++; if (gnt_o !== 2'b01) $display("[TB] FAIL b2b_first: got %b want 01", gnt_o); else n_pass++;
    n_checks++; if (m1_ack_o !== 1'b0) $display("[TB] FAIL b2b_m1_stall: got ack %b want 0", m1_ack_o); else n_pass++;
    @(negedge clk);
    n_checks++; if (m0_ack_o !== 1'b1) $display("[TB] FAIL b2b_m0_ack: got %b want 1", m0_ack_o); else n_pass++;
    idle_master(0);
    @(negedge clk);
    n_checks++; if (gnt_o !== 2'b10) $display("[TB] FAIL b2b_handover: got %b want 10", gnt_o); else n_pass++;
    @(negedge clk);
    n_checks++; if (m1_ack_o !== 1'b1 || m1_dat_o !== slave_rd(32'h0000_0200))
      $display("[TB] FAIL b2b_m1_read: got ack %b dat %h want 1 %h", m1_ack_o, m1_dat_o, slave_rd(32'h0000_0200)); else n_pass++;
    idle_master(1);
    repeat (2) @(negedge clk);
  endtask

  // Both masters keep re-requesting, so the grant order must strictly alternate from m0.
  task automatic test_random_alternation;
    do_reset;
    slave_lat = int'($urandom_range(1, 3));
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 4; i++) begin
          run_txn(0, $urandom & 32'h00FF_FFF0, 1'($urandom), int'($urandom_range(1, 4)));
          @(negedge clk);
        end
      end
      begin
        for (int i = 0; i < 4; i++) begin
          run_txn(1, $urandom & 32'h00FF_FFF0, 1'($urandom), (i == 1) ? 4 : int'($urandom_range(1, 4)));
          @(negedge clk);
        end
      end
    join
    n_checks++; if (grant_log.size() !== 8) $display("[TB] FAIL alt_count: got %0d want 8", grant_log.size()); else n_pass++;
    for (int i = 0; i < grant_log.size(); i++) begin
      n_checks++;
      if (grant_log[i] !== i % 2) $display("[TB] FAIL alt_order[%0d]: got m%0d want m%0d", i, grant_log[i], i % 2);
      else n_pass++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic test_watchdog;
    int err_k, pulses, errs, ack_k;
    logic stb_fire, stb_pre, other_err;
    do_reset;
    slave_mute = 1'b1;
    raise_master(1, $urandom & 32'h00FF_FFFC, 3'b000);
    err_k = -1; pulses = 0; errs = 0; stb_fire = 1'b1; stb_pre = 1'b0; other_err = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (m1_err_o) begin
        errs++;
        if (err_k < 0) begin
          err_k    = k;
          stb_fire = s_stb_o;
        end
      end
      if (timeout_o) pulses++;
      if (m0_err_o) other_err = 1'b1;
      if (k == 15) stb_pre = s_stb_o;
    end
    n_checks++; if (err_k !== 16) $display("[TB] FAIL wd_err_clock: got %0d want 16", err_k); else n_pass++;
    n_checks++; if (errs !== 1) $display("[TB] FAIL wd_err_count: got %0d want 1", errs); else n_pass++;
    n_checks++; if (pulses !== 1) $display("[TB] FAIL wd_pulse_count: got %0d want 1", pulses); else n_pass++;
    n_checks++; if (stb_fire !== 1'b0) $display("[TB] FAIL wd_stb_forced: got %b want 0", stb_fire); else n_pass++;
    n_checks++; if (stb_pre !== 1'b1) $display("[TB] FAIL wd_stb_before: got %b want 1", stb_pre); else n_pass++;
    n_checks++; if (other_err !== 1'b0) $display("[TB] FAIL wd_nonowner_err: got %b want 0", other_err); else n_pass++;
    idle_master(1);
    @(negedge clk);
    slave_mute = 1'b0;
    slave_lat  = 15;
    raise_master(1, $urandom & 32'h00FF_FFFC, 3'b000);
    ack_k = -1; errs = 0; pulses = 0;
    for (int k = 1; k <= 30 && ack_k < 0; k++) begin
      @(negedge clk);
      if (m1_err_o) errs++;
      if (timeout_o) pulses++;
      if (m1_ack_o) ack_k = k;
    end
    n_checks++; if (ack_k !== 16) $display("[TB] FAIL wd_late_ack_clock: got %0d want 16", ack_k); else n_pass++;
    n_checks++; if (errs !== 0 || pulses !== 0)
      $display("[TB] FAIL wd_ack_priority: got err %0d pulses %0d want 0 0", errs, pulses); else n_pass++;
    idle_master(1);
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_burst;
    do_reset;
    slave_lat = 3;
    raise_master(1, 32'h0000_4000, 3'b010);
    repeat (2) @(negedge clk);
    n_checks++; if (gnt_o !== 2'b10) $display("[TB] FAIL rstmid_owner: got %b want 10", gnt_o); else n_pass++;
    raise_master(0, 32'h0000_5000, 3'b000);
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0)
      $display("[TB] FAIL rstmid_slave_req: got cyc %b stb %b want 0 0", s_cyc_o, s_stb_o); else n_pass++;
    n_checks++; if (gnt_o !== 2'b00) $display("[TB] FAIL rstmid_gnt: got %b want 00", gnt_o); else n_pass++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (gnt_o !== 2'b01) $display("[TB] FAIL rstmid_tie: got %b want 01", gnt_o); else n_pass++;
    idle_master(0);
    idle_master(1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL global_timeout: simulation did not finish within bound");
    $fatal(1, "[TB] aborted");
  end

  initial begin
    rst = 1'b1;
    idle_master(0);
    idle_master(1);
    @(negedge clk);
    test_reset;
    test_single_read;
    test_back_to_back;
    test_random_alternation;
    test_watchdog;
    test_reset_mid_burst;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
